// File: rtl/cache_pkg.sv
// cache_pkg
// Shared definitions for the direct-mapped read cache controller:
// default address-field widths, FSM state encoding and two small helpers
// (line word select, saturating counter increment).
package cache_pkg;

    // Word address layout is {tag, index, offset}.
    localparam int ADDR_W   = 15;
    localparam int INDEX_W  = 10;
    localparam int OFFSET_W = 2;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

    // Controller states.
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] COMPARE  = 2'd1;
    localparam logic [1:0] MEM_WAIT = 2'd2;
    localparam logic [1:0] RESPOND  = 2'd3;

    // Pick one 32-bit word out of a 128-bit line; offset 0 is bits 31:0.
    function automatic logic [31:0] selectWord(input logic [127:0] line,
                                               input logic [1:0]   offset);
        return line[{offset, 5'd0} +: 32];
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] satInc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/cache_tag_memory.sv
// cache_tag_memory
// Tag and valid storage for the direct-mapped cache.
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low clear of all valid bits
//   rdIndex  in   lookup index (combinational read)
//   rdTag    out  stored tag at rdIndex
//   rdValid  out  valid bit at rdIndex
//   wrEn     in   write strobe: store wrTag and set valid at wrIndex
//   wrIndex  in   write index
//   wrTag    in   tag to store
module cache_tag_memory #(
    parameter int INDEX_W = cache_pkg::INDEX_W,
    parameter int TAG_W   = cache_pkg::TAG_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rdIndex,
    output logic [TAG_W-1:0]   rdTag,
    output logic               rdValid,
    input  logic               wrEn,
    input  logic [INDEX_W-1:0] wrIndex,
    input  logic [TAG_W-1:0]   wrTag
);
    import cache_pkg::*;

    localparam int DEPTH = 1 << INDEX_W;

    // Tag contents are never cleared; a line is only trusted via its valid bit.
    logic [TAG_W-1:0] tagArray [DEPTH];
    logic [DEPTH-1:0] validBits;

    always_ff @(posedge clk) begin
        if (wrEn) begin
            tagArray[wrIndex] <= wrTag;
        end
    end

    // One flop per line so the whole valid vector clears asynchronously.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gValid
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                validBits[gi] <= 1'b0;
            end else if (wrEn && (wrIndex == INDEX_W'(gi))) begin
                validBits[gi] <= 1'b1;
            end
        end
    end

    assign rdTag   = tagArray[rdIndex];
    assign rdValid = validBits[rdIndex];

endmodule

// File: rtl/cache_controller.sv
// cache_controller
// Direct-mapped, read-only cache controller with an external data array.
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   cpuReq, cpuAddr     CPU read request and word address {tag,index,offset}
//   cpuReady, cpuData   one-cycle response strobe and read word
//   hit                 qualifies cpuReady: 1 = hit, 0 = miss
//   memReq, memAddr     line refill request and line address {tag,index}
//   memReady, memData   refill line valid and data
//   dmWrEn, dmAddr      data-array write enable and index
//   dmInData, dmOutData data-array write data and combinational read data
//   hitCount, missCount saturating event counters
module cache_controller #(
    parameter int ADDR_W   = cache_pkg::ADDR_W,
    parameter int INDEX_W  = cache_pkg::INDEX_W,
    parameter int OFFSET_W = cache_pkg::OFFSET_W,
    parameter int TAG_W    = ADDR_W - INDEX_W - OFFSET_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpuReq,
    input  logic [ADDR_W-1:0]        cpuAddr,
    output logic                     cpuReady,
    output logic [31:0]              cpuData,
    output logic                     hit,
    output logic                     memReq,
    output logic [TAG_W+INDEX_W-1:0] memAddr,
    input  logic                     memReady,
    input  logic [127:0]             memData,
    output logic                     dmWrEn,
    output logic [INDEX_W-1:0]       dmAddr,
    output logic [127:0]             dmInData,
    input  logic [127:0]             dmOutData,
    output logic [15:0]              hitCount,
    output logic [15:0]              missCount
);
    import cache_pkg::*;

    logic [1:0]          stateReg, stateNext;
    logic [ADDR_W-1:0]   addrReg;
    logic [15:0]         hitCountReg, missCountReg;

    logic [TAG_W-1:0]    latchedTag;
    logic [INDEX_W-1:0]  latchedIndex;
    logic [OFFSET_W-1:0] latchedOffset;
    logic [TAG_W-1:0]    storedTag;
    logic                storedValid;
    logic                lookupHit;
    logic                compareHit;

    assign latchedTag    = addrReg[ADDR_W-1 -: TAG_W];
    assign latchedIndex  = addrReg[OFFSET_W +: INDEX_W];
    assign latchedOffset = addrReg[OFFSET_W-1:0];

    cache_tag_memory #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) tagMem (
        .clk     (clk),
        .rst     (rst),
        .rdIndex (latchedIndex),
        .rdTag   (storedTag),
        .rdValid (storedValid),
        .wrEn    (dmWrEn),
        .wrIndex (latchedIndex),
        .wrTag   (latchedTag)
    );

    assign lookupHit  = storedValid && (storedTag == latchedTag);
    assign compareHit = (stateReg == COMPARE) && lookupHit;

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:     if (cpuReq) stateNext = COMPARE;
            COMPARE:  stateNext = lookupHit ? IDLE : MEM_WAIT;
            MEM_WAIT: if (memReady) stateNext = RESPOND;
            RESPOND:  stateNext = IDLE;
            default:  stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg     <= IDLE;
            addrReg      <= '0;
            hitCountReg  <= '0;
            missCountReg <= '0;
        end else begin
            stateReg <= stateNext;
            if ((stateReg == IDLE) && cpuReq) begin
                addrReg <= cpuAddr;
            end
            if (compareHit) begin
                hitCountReg <= satInc(hitCountReg);
            end
            if (stateReg == RESPOND) begin
                missCountReg <= satInc(missCountReg);
            end
        end
    end

    // All outputs decode from the state register, so an asynchronous reset
    // drops them immediately. A refilled line is written at the MEM_WAIT
    // edge, so in RESPOND the external array already returns the new line.
    assign cpuReady  = compareHit || (stateReg == RESPOND);
    assign hit       = compareHit;
    assign cpuData   = cpuReady ? selectWord(dmOutData, 2'(latchedOffset)) : 32'd0;
    assign memReq    = (stateReg == MEM_WAIT);
    assign memAddr   = memReq ? {latchedTag, latchedIndex} : '0;
    assign dmWrEn    = memReq && memReady;
    assign dmInData  = dmWrEn ? memData : 128'd0;
    // In IDLE the array is addressed straight from the CPU so the line is
    // already on dmOutData when COMPARE evaluates the hit.
    assign dmAddr    = (stateReg == IDLE) ? cpuAddr[OFFSET_W +: INDEX_W] : latchedIndex;
    assign hitCount  = hitCountReg;
    assign missCount = missCountReg;

endmodule

// File: tb/tb_cache_controller.sv
module tb_cache_controller;

    logic         clk;
    logic         rst;
    logic         cpuReq;
    logic [14:0]  cpuAddr;
    logic         cpuReady;
    logic [31:0]  cpuData;
    logic         hit;
    logic         memReq;
    logic [12:0]  memAddr;
    logic         memReady;
    logic [127:0] memData;
    logic         dmWrEn;
    logic [9:0]   dmAddr;
    logic [127:0] dmInData;
    logic [127:0] dmOutData;
    logic [15:0]  hitCount;
    logic [15:0]  missCount;

    int checks   = 0;
    int failures = 0;

    // External data array model: synchronous write, combinational read.
    logic [127:0] dataMem [1024];
    always @(posedge clk) begin
        if (dmWrEn) dataMem[dmAddr] <= dmInData;
    end
    assign dmOutData = dataMem[dmAddr];

    cache_controller dut (
        .clk       (clk),
        .rst       (rst),
        .cpuReq    (cpuReq),
        .cpuAddr   (cpuAddr),
        .cpuReady  (cpuReady),
        .cpuData   (cpuData),
        .hit       (hit),
        .memReq    (memReq),
        .memAddr   (memAddr),
        .memReady  (memReady),
        .memData   (memData),
        .dmWrEn    (dmWrEn),
        .dmAddr    (dmAddr),
        .dmInData  (dmInData),
        .dmOutData (dmOutData),
        .hitCount  (hitCount),
        .missCount (missCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] LINE_A = {32'h0000DDDD, 32'h0000CCCC, 32'h0000BBBB, 32'h0000AAAA};
    localparam logic [127:0] LINE_B = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    localparam logic [127:0] LINE_C = {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};

    task automatic checkValue(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full miss transaction; memReady arrives on the waitCycles-th MEM_WAIT
    // cycle. With poke set, cpuReq and memReady are pulsed during RESPOND.
    task automatic missTxn(input logic [14:0] addr, input logic [127:0] line,
                           input int waitCycles, input logic [12:0] expMemAddr,
                           input logic [31:0] expWord, input logic [15:0] expMiss,
                           input bit poke);
        logic [9:0] idx;
        idx = addr[11:2];
        cpuReq  = 1'b1;
        cpuAddr = addr;
        #1;
        checkValue("miss idle dmAddr", dmAddr, idx);
        tick();
        cpuReq  = 1'b0;
        cpuAddr = ~addr;
        #1;
        checkValue("miss compare cpuReady", cpuReady, 1'b0);
        checkValue("miss compare memReq", memReq, 1'b0);
        checkValue("miss compare dmAddr latched", dmAddr, idx);
        tick();
        for (int i = 0; i < waitCycles; i++) begin
            checkValue("miss wait memReq", memReq, 1'b1);
            checkValue("miss wait memAddr", memAddr, expMemAddr);
            checkValue("miss wait cpuReady", cpuReady, 1'b0);
            if (i == waitCycles - 1) begin
                memReady = 1'b1;
                memData  = line;
                #1;
                checkValue("miss refill dmWrEn", dmWrEn, 1'b1);
                checkValue("miss refill dmInData", dmInData, line);
            end else begin
                checkValue("miss wait dmWrEn", dmWrEn, 1'b0);
            end
            tick();
        end
        memReady = 1'b0;
        memData  = '0;
        #1;
        checkValue("miss respond cpuReady", cpuReady, 1'b1);
        checkValue("miss respond hit", hit, 1'b0);
        checkValue("miss respond cpuData", cpuData, expWord);
        checkValue("miss respond memReq", memReq, 1'b0);
        if (poke) begin
            cpuReq   = 1'b1;
            cpuAddr  = addr;
            memReady = 1'b1;
            memData  = LINE_B;
            #1;
            checkValue("respond poke dmWrEn", dmWrEn, 1'b0);
        end
        tick();
        cpuReq   = 1'b0;
        memReady = 1'b0;
        memData  = '0;
        #1;
        checkValue("miss done cpuReady", cpuReady, 1'b0);
        checkValue("miss done memReq", memReq, 1'b0);
        checkValue("miss done missCount", missCount, expMiss);
        if (poke) begin
            tick();
            checkValue("respond poke no reply", cpuReady, 1'b0);
            checkValue("respond poke no memReq", memReq, 1'b0);
            checkValue("respond poke missCount", missCount, expMiss);
        end
        $display("miss addr=%h word=%h missCount=%0d", addr, cpuData, missCount);
    endtask

    // Hit transaction; with poke set, cpuReq and memReady are pulsed in COMPARE.
    task automatic hitTxn(input logic [14:0] addr, input logic [31:0] expWord,
                          input logic [15:0] expHit, input bit poke);
        cpuReq  = 1'b1;
        cpuAddr = addr;
        tick();
        cpuReq  = poke;
        memReady = poke;
        memData  = LINE_B;
        cpuAddr  = 15'h7FFF;
        #1;
        checkValue("hit cpuReady", cpuReady, 1'b1);
        checkValue("hit hit", hit, 1'b1);
        checkValue("hit cpuData", cpuData, expWord);
        checkValue("hit memReq", memReq, 1'b0);
        checkValue("hit dmWrEn", dmWrEn, 1'b0);
        tick();
        cpuReq   = 1'b0;
        memReady = 1'b0;
        memData  = '0;
        #1;
        checkValue("hit done cpuReady", cpuReady, 1'b0);
        checkValue("hit done hit", hit, 1'b0);
        checkValue("hit done cpuData", cpuData, 32'd0);
        checkValue("hit done hitCount", hitCount, expHit);
        if (poke) begin
            tick();
            checkValue("compare poke no reply", cpuReady, 1'b0);
            checkValue("compare poke no memReq", memReq, 1'b0);
        end
        $display("hit addr=%h hitCount=%0d", addr, hitCount);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) dataMem[i] = '0;
        rst      = 1'b0;
        cpuReq   = 1'b0;
        cpuAddr  = '0;
        memReady = 1'b0;
        memData  = '0;
        repeat (3) tick();
        checkValue("reset cpuReady", cpuReady, 1'b0);
        checkValue("reset hit", hit, 1'b0);
        checkValue("reset memReq", memReq, 1'b0);
        checkValue("reset dmWrEn", dmWrEn, 1'b0);
        checkValue("reset cpuData", cpuData, 32'd0);
        checkValue("reset memAddr", memAddr, 13'd0);
        checkValue("reset dmInData", dmInData, 128'd0);
        checkValue("reset hitCount", hitCount, 16'd0);
        checkValue("reset missCount", missCount, 16'd0);
        rst = 1'b1;
        tick();

        // Cold miss, refill after 3 MEM_WAIT cycles.
        missTxn(15'h0004, LINE_A, 3, 13'h001, 32'h0000AAAA, 16'd1, 1'b0);
        // Hits on the cached line at several offsets.
        hitTxn(15'h0004, 32'h0000AAAA, 16'd1, 1'b0);
        hitTxn(15'h0007, 32'h0000DDDD, 16'd2, 1'b0);
        hitTxn(15'h0006, 32'h0000CCCC, 16'd3, 1'b0);
        // Conflict on the same index, then the original tag misses again.
        missTxn(15'h1004, LINE_B, 1, 13'h401, 32'h11111111, 16'd2, 1'b0);
        missTxn(15'h0004, LINE_A, 2, 13'h001, 32'h0000AAAA, 16'd3, 1'b0);
        // Stray cpuReq/memReady in COMPARE and RESPOND.
        hitTxn(15'h0005, 32'h0000BBBB, 16'd4, 1'b1);
        missTxn(15'h000B, LINE_C, 2, 13'h002, 32'hC3C3C3C3, 16'd4, 1'b1);

        // Reset in the middle of a refill to index 3.
        cpuReq  = 1'b1;
        cpuAddr = 15'h000C;
        tick();
        cpuReq = 1'b0;
        tick();
        checkValue("abort wait memReq", memReq, 1'b1);
        rst = 1'b0;
        #1;
        checkValue("abort async memReq", memReq, 1'b0);
        checkValue("abort async memAddr", memAddr, 13'd0);
        checkValue("abort async missCount", missCount, 16'd0);
        checkValue("abort async hitCount", hitCount, 16'd0);
        memReady = 1'b1;
        memData  = LINE_B;
        #1;
        checkValue("abort dmWrEn", dmWrEn, 1'b0);
        tick();
        checkValue("abort no array write", dataMem[3], 128'd0);
        memReady = 1'b0;
        memData  = '0;
        rst = 1'b1;
        tick();
        missTxn(15'h0004, LINE_A, 1, 13'h001, 32'h0000AAAA, 16'd1, 1'b0);

        // Saturation: preset hitCount just below the limit.
        force dut.hitCountReg = 16'hFFFD;
        #1;
        release dut.hitCountReg;
        #1;
        checkValue("preset hitCount", hitCount, 16'hFFFD);
        tick();
        hitTxn(15'h0004, 32'h0000AAAA, 16'hFFFE, 1'b0);
        hitTxn(15'h0005, 32'h0000BBBB, 16'hFFFF, 1'b0);
        hitTxn(15'h0006, 32'h0000CCCC, 16'hFFFF, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
